updown_counter_param: RTL and testbench
=======================================

Name: updown_counter_param

Overview:
- Parametrised up/down counter. Successor to the team's fixed 4-bit up/down counter.
- Adds: configurable width, runtime-programmable upper limit (modulo-N), wrap or saturate mode, synchronous load, count enable, and boundary event flags.
- Used as the shared timebase/position counter in control datapaths that need bidirectional counting with a programmable range.

Parameters:
- WIDTH, 8, counter width in bits (valid range 2..32).
- RESET_VAL, 0, value loaded into count on reset; must be <= (2^WIDTH)-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  count enable; when 0, count holds (load still honoured).
- up  input  1  direction: 1 = increment, 0 = decrement.
- sat_mode  input  1  0 = wrap at boundaries, 1 = saturate at boundaries.
- limit  input  WIDTH  inclusive upper bound of the count range 0..limit.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value to load.
- count  output  WIDTH  current count (registered).
- wrap  output  1  registered 1-cycle pulse; high the cycle after a wrap occurred.
- sat  output  1  registered 1-cycle pulse; high the cycle after a step was blocked by saturation.
- at_max  output  1  combinational: count == limit.
- at_min  output  1  combinational: count == 0.

Behaviour:
- Priority, evaluated each rising edge: rst > load > en > hold.
- rst=1: count <= RESET_VAL, wrap <= 0, sat <= 0.
- load=1: count <= min(load_val, limit). wrap and sat <= 0. Load ignores en and up.
- en=1, up=1:
  - count < limit: count <= count+1.
  - count >= limit, sat_mode=0: count <= 0, wrap <= 1.
  - count >= limit, sat_mode=1: count <= limit, sat <= 1.
- en=1, up=0:
  - count > limit (limit lowered mid-run): count <= limit. Neither flag set.
  - 0 < count <= limit: count <= count-1.
  - count == 0, sat_mode=0: count <= limit, wrap <= 1.
  - count == 0, sat_mode=1: count stays 0, sat <= 1.
- en=0, no load: count holds; wrap and sat <= 0.
- wrap and sat:
  - Cleared every cycle in which their setting condition is false; never both high.
  - Latency: the flag appears on the same edge that updates count to the boundary result.
- limit=0: the counter is pinned at 0. Every enabled step produces a wrap or sat pulse (per sat_mode); count remains 0.
- Arithmetic:
  - Unsigned, WIDTH bits.
  - No internal overflow: next-value comparison uses count versus limit, not carry-out.
  - limit = 2^WIDTH-1 gives plain modulo-2^WIDTH behaviour identical to the legacy counter.
- Inputs up, sat_mode and limit may change on any cycle; each edge uses the values sampled at that edge.
- Reset mid-run overrides any simultaneous load or en. No state survives reset.

Decomposition:
- Shared package updown_counter_pkg:
  - Localparams DIR_UP=1'b1, DIR_DOWN=1'b0, MODE_WRAP=1'b0, MODE_SAT=1'b1.
  - A function clamp(val, limit) used by the load path.
- One natural sub-module: updown_next_calc.
  - Purely combinational.
  - Inputs: count, limit, up, sat_mode. Outputs: next_count, wrap_ev, sat_ev.
  - The top level holds only registers and priority muxing, so the boundary logic can be unit-tested in isolation.

Test Plan:
1. WIDTH=4, reset -> count=0. limit=9, sat_mode=0, up=1, en=1 for 12 cycles -> count 1..9, 0, 1, 2. wrap pulses exactly on the edge producing 0.
2. limit=9, sat_mode=1, up=0 from count=2 for 4 cycles -> 1, 0, 0, 0. sat high for the two held cycles; wrap never high.
3. load=1, load_val=13, limit=9 -> count=9, at_max=1. Next up step with sat_mode=0 -> count=0, wrap=1, at_min=1.
4. Count at 8, limit changed to 5, up=0, en=1 -> count=5, no flags. Next edge -> 4.
5. en=1, load=1, rst=1 in the same cycle, count=7 -> count=RESET_VAL (0), flags 0. Then en=0 for 3 cycles -> count holds, flags stay 0.
6. limit=15, sat_mode=0, up=0 from count=0 -> count=15, wrap=1. Confirms equivalence with the legacy 4-bit counter.

Source files
------------

// File: rtl/updown_counter_pkg.sv
// ============================================================================
// updown_counter_pkg : shared direction/mode encodings and load clamp helper
// Revision: 1.0
// ============================================================================
`default_nettype none

package updown_counter_pkg;

   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;

   // Operates at the widest legal WIDTH; callers zero-extend and truncate.
   function automatic logic [31:0] clamp(input logic [31:0] val, input logic [31:0] limit);
      return (val > limit) ? limit : val;
   endfunction

endpackage

`default_nettype wire

// File: rtl/updown_next_calc.sv
// ============================================================================
// updown_next_calc : combinational next-count and boundary event evaluation
// Revision: 1.0
// ============================================================================
`default_nettype none

module updown_next_calc
   import updown_counter_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] count,
   input  logic [WIDTH-1:0] limit,
   input  logic             up,
   input  logic             sat_mode,
   output logic [WIDTH-1:0] next_count,
   output logic             wrap_ev,
   output logic             sat_ev
);

   always_comb begin
      next_count = count;
      wrap_ev    = 1'b0;
      sat_ev     = 1'b0;
      if (up == DIR_UP) begin
         // Compare against limit rather than relying on carry-out.
         if (count < limit) begin
            next_count = count + 1'b1;
         end else if (sat_mode == MODE_SAT) begin
            next_count = limit;
            sat_ev     = 1'b1;
         end else begin
            next_count = '0;
            wrap_ev    = 1'b1;
         end
      end else begin
         if (count > limit) begin
            next_count = limit;
         end else if (count != '0) begin
            next_count = count - 1'b1;
         end else if (sat_mode == MODE_SAT) begin
            next_count = '0;
            sat_ev     = 1'b1;
         end else begin
            next_count = limit;
            wrap_ev    = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/updown_counter_param.sv
// ============================================================================
// updown_counter_param : parametrised up/down counter, programmable limit,
//                        wrap/saturate modes, load and boundary event pulses
// Revision: 1.0
// ============================================================================
`default_nettype none

module updown_counter_param
   import updown_counter_pkg::*;
#(
   parameter int                WIDTH     = 8,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             sat_mode,
   input  logic [WIDTH-1:0] limit,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             wrap,
   output logic             sat,
   output logic             at_max,
   output logic             at_min
);

   logic [WIDTH-1:0] r_count;
   logic             r_wrap;
   logic             r_sat;
   logic [WIDTH-1:0] w_next_count;
   logic             w_wrap_ev;
   logic             w_sat_ev;
   logic [WIDTH-1:0] w_load_clamped;

   updown_next_calc #(
      .WIDTH (WIDTH)
   ) u_next_calc (
      .count      (r_count),
      .limit      (limit),
      .up         (up),
      .sat_mode   (sat_mode),
      .next_count (w_next_count),
      .wrap_ev    (w_wrap_ev),
      .sat_ev     (w_sat_ev)
   );

   assign w_load_clamped = WIDTH'(clamp(32'(load_val), 32'(limit)));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= RESET_VAL;
         r_wrap  <= 1'b0;
         r_sat   <= 1'b0;
      end else if (load) begin
         r_count <= w_load_clamped;
         r_wrap  <= 1'b0;
         r_sat   <= 1'b0;
      end else if (en) begin
         r_count <= w_next_count;
         r_wrap  <= w_wrap_ev;
         r_sat   <= w_sat_ev;
      end else begin
         r_wrap  <= 1'b0;
         r_sat   <= 1'b0;
      end
   end

   assign count  = r_count;
   assign wrap   = r_wrap;
   assign sat    = r_sat;
   assign at_max = (r_count == limit);
   assign at_min = (r_count == '0);

endmodule

`default_nettype wire

// File: tb/tb_updown_counter_param.sv
// ============================================================================
// tb_updown_counter_param : directed self-checking bench, WIDTH=4, RESET_VAL=0
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_updown_counter_param;

   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst, en, up, sat_mode, load;
   logic [WIDTH-1:0] limit, load_val;
   logic [WIDTH-1:0] count;
   logic             wrap, sat, at_max, at_min;

   int n_pass  = 0;
   int n_total = 0;

   updown_counter_param #(
      .WIDTH     (WIDTH),
      .RESET_VAL (4'd0)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up       (up),
      .sat_mode (sat_mode),
      .limit    (limit),
      .load     (load),
      .load_val (load_val),
      .count    (count),
      .wrap     (wrap),
      .sat      (sat),
      .at_max   (at_max),
      .at_min   (at_min)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic chk_state(input string tag, input int c, input logic w, input logic s);
      chk({tag, ".count"}, 32'(count), 32'(c));
      chk({tag, ".wrap"},  32'(wrap),  32'(w));
      chk({tag, ".sat"},   32'(sat),   32'(s));
   endtask

   initial begin
      int up_exp [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      int dn_exp [4]  = '{1, 0, 0, 0};
      logic dn_sat [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

      rst = 1'b1; en = 1'b0; up = 1'b1; sat_mode = 1'b0;
      load = 1'b0; load_val = '0; limit = 4'd9;
      step();
      chk_state("reset", 0, 1'b0, 1'b0);
      chk("reset.at_min", 32'(at_min), 32'd1);

      // Count up through limit 9 with wrap.
      rst = 1'b0; en = 1'b1; up = 1'b1; sat_mode = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         chk_state($sformatf("up_wrap[%0d]", i), up_exp[i], (i == 9), 1'b0);
      end

      // Count down from 2 with saturation.
      sat_mode = 1'b1; up = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_state($sformatf("dn_sat[%0d]", i), dn_exp[i], 1'b0, dn_sat[i]);
      end

      // Load above limit clamps; ignores en/up.
      load = 1'b1; load_val = 4'd13;
      step();
      chk_state("load_clamp", 9, 1'b0, 1'b0);
      chk("load_clamp.at_max", 32'(at_max), 32'd1);
      load = 1'b0; up = 1'b1; sat_mode = 1'b0;
      step();
      chk_state("load_then_wrap", 0, 1'b1, 1'b0);
      chk("load_then_wrap.at_min", 32'(at_min), 32'd1);

      // Limit lowered below count while counting down.
      load = 1'b1; load_val = 4'd8;
      step();
      chk_state("load8", 8, 1'b0, 1'b0);
      load = 1'b0; limit = 4'd5; up = 1'b0;
      step();
      chk_state("limit_drop", 5, 1'b0, 1'b0);
      chk("limit_drop.at_max", 32'(at_max), 32'd1);
      step();
      chk_state("limit_drop_next", 4, 1'b0, 1'b0);

      // Reset beats simultaneous load and enable.
      load = 1'b1; load_val = 4'd7; limit = 4'd9;
      step();
      chk_state("load7", 7, 1'b0, 1'b0);
      rst = 1'b1; load = 1'b1; load_val = 4'd3; en = 1'b1;
      step();
      chk_state("rst_priority", 0, 1'b0, 1'b0);
      rst = 1'b0; load = 1'b0; en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_state($sformatf("hold0[%0d]", i), 0, 1'b0, 1'b0);
      end

      // Hold at a nonzero value.
      load = 1'b1; load_val = 4'd3;
      step();
      load = 1'b0; up = 1'b1;
      step();
      chk_state("hold3", 3, 1'b0, 1'b0);

      // limit=0 pins the count; every step pulses.
      limit = 4'd0; en = 1'b1; up = 1'b1; sat_mode = 1'b0;
      step();
      chk_state("lim0_up_wrap", 0, 1'b1, 1'b0);
      sat_mode = 1'b1;
      step();
      chk_state("lim0_up_sat", 0, 1'b0, 1'b1);
      up = 1'b0; sat_mode = 1'b0;
      step();
      chk_state("lim0_dn_wrap", 0, 1'b1, 1'b0);

      // Full-range limit behaves like the legacy 4-bit counter.
      limit = 4'd15; sat_mode = 1'b0; up = 1'b0;
      step();
      chk_state("legacy_dn_wrap", 15, 1'b1, 1'b0);
      up = 1'b1;
      step();
      chk_state("legacy_up_wrap", 0, 1'b1, 1'b0);
      en = 1'b0;
      step();
      chk_state("legacy_idle", 0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
